sine_nco_scheduler: RTL and testbench

Time-multiplexes the single 1024-entry sine LUT generator across NUM_CH independent NCO channels. It holds a frequency tuning word (FTW), a phase offset and a phase accumulator per channel. On each sample tick it runs one round, issuing every channel's phase to the LUT generator in turn. Each returned 24-bit sample comes back tagged with its channel number. The block sits between the sample-rate timing logic or register interface and the sine generator, and drives that generator's `phase_acc` input directly.

---
 rtl/sine_nco_scheduler.sv | 155 +++++++++++++++
 tb/tb_sine_nco_scheduler.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sine_nco_scheduler.sv
// Time-multiplexes one registered sine LUT across NUM_CH NCO channels.
// Each tick runs a fixed-length round: issue every channel's phase, then drain the LUT pipeline.
module sine_nco_scheduler #(
    parameter int NUM_CH = 4,
    parameter int CH_W   = (NUM_CH > 2) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              tick_i,
    input  logic [NUM_CH-1:0] ch_enable_i,
    input  logic              sync_clr_i,
    input  logic              cfg_we_i,
    input  logic              cfg_sel_i,
    input  logic [CH_W-1:0]   cfg_ch_i,
    input  logic [31:0]       cfg_data_i,
    input  logic              ovr_clr_i,
    output logic [31:0]       phase_acc_o,
    input  logic [23:0]       sine_wave_i,
    output logic              out_valid_o,
    output logic [CH_W-1:0]   out_ch_o,
    output logic [23:0]       out_sample_o,
    output logic              busy_o,
    output logic              overrun_o
);
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

    state_t            state_q;
    logic [CH_W-1:0]   idx_q;
    logic              drain_q;
    logic [NUM_CH-1:0] mask_q;
    logic              busy_q;
    logic              overrun_q;

    logic [31:0]       phase_q;
    logic              tag1_en_q, tag2_en_q;
    logic [CH_W-1:0]   tag1_ch_q, tag2_ch_q;
    logic              out_valid_q;
    logic [CH_W-1:0]   out_ch_q;
    logic [23:0]       out_sample_q;

    logic              issue;
    logic [31:0]       phase_all [NUM_CH];

    assign issue = (state_q == ISSUE);

    // Per-channel tuning word, offset and accumulator.
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        localparam logic [CH_W-1:0] CH = CH_W'(gi);
        logic [31:0] ftw_q, off_q, acc_q, acc_d;
        logic        cfg_hit;

        assign cfg_hit      = cfg_we_i && (cfg_ch_i == CH);
        assign phase_all[gi] = acc_q + off_q;

        always_comb begin
            acc_d = acc_q;
            if (sync_clr_i)
                acc_d = '0;
            else if (issue && (idx_q == CH) && mask_q[gi])
                acc_d = acc_q + ftw_q;
        end

        always_ff @(posedge clk_i or posedge reset_i) begin
            if (reset_i) begin
                ftw_q <= '0;
                off_q <= '0;
                acc_q <= '0;
            end else begin
                if (cfg_hit && !cfg_sel_i) ftw_q <= cfg_data_i;
                if (cfg_hit && cfg_sel_i)  off_q <= cfg_data_i;
                acc_q <= acc_d;
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            drain_q   <= 1'b0;
            mask_q    <= '0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (tick_i) begin
                        state_q <= ISSUE;
                        idx_q   <= '0;
                        mask_q  <= ch_enable_i;
                        busy_q  <= 1'b1;
                    end
                end
                ISSUE: begin
                    idx_q <= idx_q + 1'b1;
                    if (idx_q == LAST_CH) begin
                        state_q <= DRAIN;
                        drain_q <= 1'b0;
                    end
                end
                DRAIN: begin
                    drain_q <= 1'b1;
                    if (drain_q) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
            // A late tick sets the flag even when a clear arrives on the same edge.
            if (tick_i && (state_q != IDLE))
                overrun_q <= 1'b1;
            else if (ovr_clr_i)
                overrun_q <= 1'b0;
        end
    end

    // Tag stage 2 lines up with the sample the LUT registered from our phase.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            phase_q      <= '0;
            tag1_en_q    <= 1'b0;
            tag1_ch_q    <= '0;
            tag2_en_q    <= 1'b0;
            tag2_ch_q    <= '0;
            out_valid_q  <= 1'b0;
            out_ch_q     <= '0;
            out_sample_q <= '0;
        end else begin
            if (issue)
                phase_q <= phase_all[idx_q];
            tag1_en_q   <= issue && mask_q[idx_q];
            tag1_ch_q   <= idx_q;
            tag2_en_q   <= tag1_en_q;
            tag2_ch_q   <= tag1_ch_q;
            out_valid_q <= tag2_en_q;
            if (tag2_en_q) begin
                out_ch_q     <= tag2_ch_q;
                out_sample_q <= sine_wave_i;
            end
        end
    end

    assign phase_acc_o  = phase_q;
    assign out_valid_o  = out_valid_q;
    assign out_ch_o     = out_ch_q;
    assign out_sample_o = out_sample_q;
    assign busy_o       = busy_q;
    assign overrun_o    = overrun_q;
endmodule

// File: tb/tb_sine_nco_scheduler.sv
// Bench for sine_nco_scheduler: drives rounds with directed and random configs and
// checks every output slot against a per-channel phase model and a stand-in sine LUT.
module tb_sine_nco_scheduler;
    localparam int N    = 4;
    localparam int CW   = 2;
    localparam int KMAX = N + 3;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          tick = 1'b0, sync_clr = 1'b0, cfg_we = 1'b0, cfg_sel = 1'b0, ovr_clr = 1'b0;
    logic [N-1:0]  ch_enable = '0;
    logic [CW-1:0] cfg_ch = '0;
    logic [31:0]   cfg_data = '0;
    logic [31:0]   phase_acc;
    logic [23:0]   sine_wave = '0;
    logic          out_valid, busy, overrun;
    logic [CW-1:0] out_ch;
    logic [23:0]   out_sample;

    int n_total = 0;
    int n_bad   = 0;

    // Reference model state and per-round expectations/observations.
    logic [31:0] m_ftw [N], m_off [N], m_acc [N];
    logic        e_v [KMAX+1];
    logic [CW-1:0] e_ch [KMAX+1];
    logic [23:0] e_s [KMAX+1];
    logic [31:0] e_ph [N];
    logic        o_v [KMAX+1], o_busy [KMAX+1];
    logic [CW-1:0] o_ch [KMAX+1];
    logic [23:0] o_s [KMAX+1];
    logic [31:0] o_ph [N];
    logic        extra_v;

    sine_nco_scheduler #(.NUM_CH(N)) dut (
        .clk_i(clk), .reset_i(reset), .tick_i(tick), .ch_enable_i(ch_enable),
        .sync_clr_i(sync_clr), .cfg_we_i(cfg_we), .cfg_sel_i(cfg_sel), .cfg_ch_i(cfg_ch),
        .cfg_data_i(cfg_data), .ovr_clr_i(ovr_clr), .phase_acc_o(phase_acc),
        .sine_wave_i(sine_wave), .out_valid_o(out_valid), .out_ch_o(out_ch),
        .out_sample_o(out_sample), .busy_o(busy), .overrun_o(overrun)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] lut(input logic [9:0] a);
        return {4'h5, a, ~a};
    endfunction

    // Stand-in sine generator: one-cycle registered lookup on the top 10 phase bits.
    always @(posedge clk) sine_wave <= lut(phase_acc[31:22]);

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_ftw[i] = '0; m_off[i] = '0; m_acc[i] = '0;
        end
    endtask

    task automatic model_round(input logic [N-1:0] mask);
        for (int k = 0; k <= KMAX; k++) begin
            e_v[k] = 1'b0; e_ch[k] = '0; e_s[k] = '0;
        end
        for (int i = 0; i < N; i++) begin
            e_ph[i] = m_acc[i] + m_off[i];
            if (mask[i]) begin
                e_v[3+i]  = 1'b1;
                e_ch[3+i] = CW'(i);
                e_s[3+i]  = lut(e_ph[i][31:22]);
                m_acc[i]  = m_acc[i] + m_ftw[i];
            end
        end
    endtask

    task automatic cfg_write(input int ch, input logic sel, input logic [31:0] data);
        @(negedge clk);
        cfg_we = 1'b1; cfg_sel = sel; cfg_ch = CW'(ch); cfg_data = data;
        @(negedge clk);
        cfg_we = 1'b0;
        if (sel) m_off[ch] = data; else m_ftw[ch] = data;
    endtask

    task automatic pulse_sync_clr();
        @(negedge clk); sync_clr = 1'b1;
        @(negedge clk); sync_clr = 1'b0;
        for (int i = 0; i < N; i++) m_acc[i] = '0;
    endtask

    // One round; again_k > 0 re-ticks so that the extra tick is sampled at E(again_k).
    task automatic run_round(input logic [N-1:0] mask, input int again_k, input logic clr_with);
        model_round(mask);
        extra_v = 1'b0;
        @(negedge clk); tick = 1'b1; ch_enable = mask;
        @(negedge clk); tick = 1'b0;
        o_busy[0] = busy; o_v[0] = out_valid; o_ch[0] = out_ch; o_s[0] = out_sample;
        if (again_k == 1) begin tick = 1'b1; ovr_clr = clr_with; ch_enable = '1; end
        for (int k = 1; k <= KMAX + 3; k++) begin
            @(negedge clk);
            tick = 1'b0; ovr_clr = 1'b0;
            if (k <= KMAX) begin
                o_busy[k] = busy; o_v[k] = out_valid; o_ch[k] = out_ch; o_s[k] = out_sample;
            end else begin
                extra_v = extra_v | out_valid;
            end
            if (k <= N) o_ph[k-1] = phase_acc;
            if (k + 1 == again_k) begin tick = 1'b1; ovr_clr = clr_with; ch_enable = '1; end
        end
    endtask

    task automatic test_reset();
        model_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_total++; if (phase_acc !== 32'h0) begin n_bad++; $display("FAIL reset phase_acc got=%h want=0", phase_acc); end
        n_total++; if (out_valid !== 1'b0 || out_ch !== '0 || out_sample !== '0) begin n_bad++; $display("FAIL reset out got v=%b ch=%0d s=%h want 0", out_valid, out_ch, out_sample); end
        n_total++; if (busy !== 1'b0 || overrun !== 1'b0) begin n_bad++; $display("FAIL reset flags got busy=%b ovr=%b want 0", busy, overrun); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        run_round(4'hF, 0, 1'b0);
        for (int k = 0; k <= KMAX; k++) begin
            n_total++;
            if (o_busy[k] !== 1'(k < N + 2)) begin n_bad++; $display("FAIL basic busy k=%0d got=%b want=%b", k, o_busy[k], k < N + 2); end
            n_total++;
            if (o_v[k] !== e_v[k] || (e_v[k] && (o_ch[k] !== e_ch[k] || o_s[k] !== e_s[k]))) begin
                n_bad++; $display("FAIL basic out k=%0d got v=%b ch=%0d s=%h want v=%b ch=%0d s=%h", k, o_v[k], o_ch[k], o_s[k], e_v[k], e_ch[k], e_s[k]);
            end
        end
        for (int k = 3; k <= 6; k++) begin
            n_total++;
            if (o_s[k] !== lut(10'd0)) begin n_bad++; $display("FAIL basic lut0 k=%0d got=%h want=%h", k, o_s[k], lut(10'd0)); end
        end
    endtask

    task automatic test_accumulate();
        cfg_write(0, 1'b0, 32'h0040_0000);
        cfg_write(1, 1'b1, 32'h4000_0000);
        pulse_sync_clr();
        cfg_write(2, 1'b0, 32'h8000_0000);
        for (int r = 0; r < 3; r++) begin
            run_round(4'hF, 0, 1'b0);
            for (int k = 0; k <= KMAX; k++) begin
                n_total++;
                if (o_v[k] !== e_v[k] || (e_v[k] && (o_ch[k] !== e_ch[k] || o_s[k] !== e_s[k]))) begin
                    n_bad++; $display("FAIL accum r=%0d k=%0d got v=%b ch=%0d s=%h want v=%b ch=%0d s=%h", r, k, o_v[k], o_ch[k], o_s[k], e_v[k], e_ch[k], e_s[k]);
                end
            end
            n_total++; if (o_s[3] !== lut(10'(r))) begin n_bad++; $display("FAIL accum ch0 r=%0d got=%h want=%h", r, o_s[3], lut(10'(r))); end
            n_total++; if (o_s[4] !== lut(10'd256) || o_ph[1] !== 32'h4000_0000) begin n_bad++; $display("FAIL offset ch1 r=%0d got s=%h ph=%h want s=%h ph=40000000", r, o_s[4], o_ph[1], lut(10'd256)); end
            n_total++; if (o_ph[2] !== ((r % 2 == 1) ? 32'h8000_0000 : 32'h0)) begin n_bad++; $display("FAIL wrap ch2 r=%0d got=%h", r, o_ph[2]); end
            n_total++; if (o_s[5] !== ((r % 2 == 1) ? lut(10'd512) : lut(10'd0))) begin n_bad++; $display("FAIL wrap ch2 sample r=%0d got=%h", r, o_s[5]); end
        end
    endtask

    task automatic test_overrun();
        run_round(4'b1010, 2, 1'b0);
        for (int k = 0; k <= KMAX; k++) begin
            n_total++;
            if (o_v[k] !== e_v[k] || (e_v[k] && (o_ch[k] !== e_ch[k] || o_s[k] !== e_s[k]))) begin
                n_bad++; $display("FAIL ovr mask k=%0d got v=%b ch=%0d s=%h want v=%b ch=%0d s=%h", k, o_v[k], o_ch[k], o_s[k], e_v[k], e_ch[k], e_s[k]);
            end
        end
        n_total++; if (extra_v !== 1'b0) begin n_bad++; $display("FAIL ovr extra round got valid=%b want 0", extra_v); end
        n_total++; if (overrun !== 1'b1) begin n_bad++; $display("FAIL ovr flag got=%b want 1", overrun); end
        @(negedge clk); ovr_clr = 1'b1;
        @(negedge clk); ovr_clr = 1'b0;
        n_total++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL ovr clear got=%b want 0", overrun); end
        // Tick on the final drain edge together with a clear: set must win.
        run_round(4'hF, N + 2, 1'b1);
        n_total++; if (overrun !== 1'b1) begin n_bad++; $display("FAIL ovr set-wins got=%b want 1", overrun); end
        n_total++; if (extra_v !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL ovr drain tick got extra=%b busy=%b want 0 0", extra_v, busy); end
        n_total++; if (o_v[6] !== 1'b1 || o_s[6] !== e_s[6]) begin n_bad++; $display("FAIL ovr last slot got v=%b s=%h want v=1 s=%h", o_v[6], o_s[6], e_s[6]); end
        @(negedge clk); ovr_clr = 1'b1;
        @(negedge clk); ovr_clr = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic seen;
        cfg_write(3, 1'b0, 32'h1234_5678);
        run_round(4'hF, 0, 1'b0);
        @(negedge clk); tick = 1'b1; ch_enable = 4'hF;
        @(negedge clk); tick = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        n_total++;
        if (phase_acc !== '0 || out_valid !== 1'b0 || out_ch !== '0 || out_sample !== '0 || busy !== 1'b0 || overrun !== 1'b0) begin
            n_bad++; $display("FAIL midreset outputs got ph=%h v=%b ch=%0d s=%h busy=%b ovr=%b want all 0", phase_acc, out_valid, out_ch, out_sample, busy, overrun);
        end
        model_reset();
        @(negedge clk); reset = 1'b0;
        seen = 1'b0;
        repeat (10) begin @(negedge clk); seen = seen | out_valid | busy; end
        n_total++; if (seen !== 1'b0) begin n_bad++; $display("FAIL midreset after got activity=%b want 0", seen); end
        run_round(4'hF, 0, 1'b0);
        for (int k = 0; k <= KMAX; k++) begin
            n_total++;
            if (o_v[k] !== e_v[k] || (e_v[k] && (o_ch[k] !== e_ch[k] || o_s[k] !== e_s[k]))) begin
                n_bad++; $display("FAIL midreset round k=%0d got v=%b ch=%0d s=%h want v=%b ch=%0d s=%h", k, o_v[k], o_ch[k], o_s[k], e_v[k], e_ch[k], e_s[k]);
            end
        end
    endtask

    task automatic test_random();
        logic [N-1:0] mask;
        for (int r = 0; r < 8; r++) begin
            for (int w = 0; w < 3; w++)
                cfg_write(int'($urandom_range(0, N - 1)), 1'($urandom_range(0, 1)), $urandom);
            if ($urandom_range(0, 3) == 0) pulse_sync_clr();
            mask = N'($urandom);
            run_round(mask, 0, 1'b0);
            for (int k = 0; k <= KMAX; k++) begin
                n_total++;
                if (o_v[k] !== e_v[k] || (e_v[k] && (o_ch[k] !== e_ch[k] || o_s[k] !== e_s[k]))) begin
                    n_bad++; $display("FAIL random r=%0d k=%0d got v=%b ch=%0d s=%h want v=%b ch=%0d s=%h", r, k, o_v[k], o_ch[k], o_s[k], e_v[k], e_ch[k], e_s[k]);
                end
            end
            for (int i = 0; i < N; i++) begin
                n_total++;
                if (o_ph[i] !== e_ph[i]) begin n_bad++; $display("FAIL random phase r=%0d ch=%0d got=%h want=%h", r, i, o_ph[i], e_ph[i]); end
            end
            n_total++;
            if (phase_acc !== e_ph[N-1]) begin n_bad++; $display("FAIL random hold r=%0d got=%h want=%h", r, phase_acc, e_ph[N-1]); end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_basic();
        test_accumulate();
        test_overrun();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
